instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction-side responder for the PC sequencing logic.
- Accepts the current fetch address (PCNext from the PC control unit) and issues a word read to instruction memory over a req/ack handshake with variable latency.
- Holds the returned word and presents the decoded Id/Imm fields back to the PC control unit, together with a stall indication.
- Stops fetching after an END instruction is returned.

Parameters:
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction word width.
- TIMEOUT, 64, maximum cycles to wait for mem_ack before raising fetch_err.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk while 0.
- start  in  1  level; fetching is permitted only while 1.
- pc  in  ADDR_W  fetch address (PCNext).
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  word address to instruction memory.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  returned instruction word.
- instr  out  DATA_W  held instruction word.
- instr_valid  out  1  instr, Id and Imm are valid this cycle.
- Id  out  4  instr[31:28], feeds the PC control unit.
- Imm  out  18  instr[17:0], feeds the PC control unit.
- stall  out  1  1 while a fetch is outstanding; PC must hold.
- halted  out  1  sticky; set once an END (Id=0001) has been fetched.
- fetch_err  out  1  sticky; set on timeout or misaligned pc.

Behaviour:
- Reset values (reset=0 at a clock edge): state=IDLE; mem_req=0; mem_addr=0; instr=0; instr_valid=0; stall=0; halted=0; fetch_err=0; timeout counter=0. Reset wins over every other event, including one arriving mid-WAIT. A mem_ack arriving during reset is dropped.
- Id and Imm are combinational slices of the instr register, so they are 0 after reset.
- FSM states: IDLE, REQ, WAIT, VALID, HALT, ERR.
- IDLE: stall=0. If start=1, pc[1:0]=00 and halted=0: latch mem_addr<=pc and go to REQ. If pc[1:0]!=00: go to ERR.
- REQ: mem_req=1 for exactly one cycle, stall=1, counter cleared; go to WAIT.
- WAIT: mem_req=0, stall=1, counter increments each cycle.
  - mem_ack=1: instr<=mem_rdata, go to VALID.
  - Counter reaches TIMEOUT-1 without ack: go to ERR.
  - If mem_ack and the timeout fire in the same cycle, ack wins.
- VALID: instr_valid=1 for one cycle, stall=0.
  - If Id==4'b0001: go to HALT.
  - Else if start=1: go to IDLE. The next address is sampled from pc in IDLE, one cycle after VALID, giving the PC register time to update.
  - Else: go to IDLE.
- HALT: halted=1; instr holds the END word; instr_valid=0; no further mem_req. Exit only by reset.
- ERR: fetch_err=1; mem_req=0; stall=1. Exit only by reset.
- Throughput: at most one instruction per 4 cycles with zero-wait memory (IDLE, REQ, WAIT with ack, VALID).
- A mem_ack outside WAIT is ignored.
- start falling to 0 during REQ/WAIT does not abort the fetch. The outstanding read completes; the unit then parks in IDLE.
- pc is sampled only in IDLE; changes in pc at any other time are ignored.

Optional Feature:
- Macro FETCH_LASTWORD_CACHE_EN: a one-entry tag/data register holding the last successfully fetched address/word pair. The entry is invalidated by reset.
- With the macro defined: in IDLE, if the cache entry is valid and pc equals its tag, go straight to VALID with instr<=cached word, with no mem_req. This gives a 2-cycle loop for a self-branch.
- Without the macro: every fetch goes through REQ/WAIT.

Test Plan:
- Reset, then start=1, pc=0x0, memory acks after 1 cycle with 0x0000_0000 -> exactly one mem_req pulse with mem_addr=0; instr_valid pulses with Id=0; stall high during REQ/WAIT.
- Fetch at pc=0x8 returning 0xC000_0100 (BRIN) -> Id=4'b1100, Imm=18'h00100 while instr_valid=1.
- Fetch returns 0x1000_0000 -> Id=0001, halted=1 the cycle after VALID; no further mem_req even with start=1 and a new pc.
- Memory never acks, TIMEOUT=64 -> fetch_err=1 after 64 WAIT cycles; stall stays 1; mem_req never re-asserts.
- pc=0x6 in IDLE with start=1 -> fetch_err=1, no mem_req issued.
- reset=0 asserted mid-WAIT, then memory acks one cycle later -> all outputs at reset values; the ack is ignored; instr stays 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: reads one word per fetch over a req/ack handshake and
// presents Id/Imm to the PC control unit. Optional last-word cache: FETCH_LASTWORD_CACHE_EN.
module instr_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [3:0]        Id,
    output logic [17:0]       Imm,
    output logic              stall,
    output logic              halted,
    output logic              fetch_err,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] VALID = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          hit;

    // Handshake: mem_req is a single-cycle pulse in REQ; the memory answers with a
    // one-cycle mem_ack carrying mem_rdata, which is only honoured while in WAIT.
    assign mem_req     = (state == REQ);
    assign stall       = (state == REQ) || (state == WAIT) || (state == ERR);
    assign instr_valid = (state == VALID);
    assign halted      = (state == HALT);
    assign fetch_err   = (state == ERR);
    assign fsm_state   = state;
    assign Id          = instr[31:28];
    assign Imm         = instr[17:0];

`ifdef FETCH_LASTWORD_CACHE_EN
    logic              c_valid;
    logic [ADDR_W-1:0] c_tag;
    logic [DATA_W-1:0] c_data;

    assign hit = c_valid && (pc == c_tag);

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_valid <= 1'b0;
            c_tag   <= '0;
            c_data  <= '0;
        end else if (state == WAIT && mem_ack) begin
            c_valid <= 1'b1;
            c_tag   <= mem_addr;
            c_data  <= mem_rdata;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            mem_addr <= '0;
            instr    <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (pc[1:0] != 2'b00) begin
                            state <= ERR;
                        end else if (hit) begin
`ifdef FETCH_LASTWORD_CACHE_EN
                            instr <= c_data;
`endif
                            mem_addr <= pc;
                            state    <= VALID;
                        end else begin
                            mem_addr <= pc;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // An ack in the timeout cycle still completes the fetch.
                    if (mem_ack) begin
                        instr <= mem_rdata;
                        state <= VALID;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                VALID: begin
                    state <= (instr[31:28] == 4'b0001) ? HALT : IDLE;
                end
                HALT:    state <= HALT;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
